conv_engine_arbiter: RTL and testbench
======================================

// Module: conv_engine_arbiter
// PURPOSE
//  Shares one 5x5 conv engine (start/done, 25 signed 8b pixels + 25 weights -> signed 32b) among
//  N_REQ requesters (e.g. per-feature-map conv controllers). Round-robin grant; holds operands
//  and start stable until done; returns result to the winner. Aborts on engine timeout.
//  Sits between the requester controllers and the single engine instance.
// PARAMETERS
//  N_REQ    4    number of requesters (>=2)
//  TIMEOUT  64   max BUSY cycles waiting for eng_done before abort (>=2)
// PORTS
//  clk         in   1            clock; all logic on posedge
//  rst_n       in   1            asynchronous active-low reset
//  req         in   N_REQ        per-requester request level
//  req_window  in   N_REQ*200    per-requester 5x5 signed 8b window, row-major, [0][0] in LSBs
//  req_weights in   N_REQ*200    per-requester 5x5 signed 8b weights, same packing
//  grant       out  N_REQ        one-hot; current owner while BUSY/RESP, else 0
//  resp_valid  out  N_REQ        one-hot 1-cycle pulse: result for that requester
//  resp_err    out  1            with resp_valid: 1 = timed out, resp_data = 0
//  resp_data   out  32 signed    result, valid only with resp_valid
//  eng_start   out  1            engine start, held high for the whole BUSY phase
//  eng_window  out  200          muxed window of owner (0 when not BUSY)
//  eng_weights out  200          muxed weights of owner (0 when not BUSY)
//  eng_rst     out  1            active-high engine reset: ~rst_n OR 1-cycle abort pulse
//  eng_done    in   1            engine done (result valid same cycle)
//  eng_result  in   32 signed    engine output
// BEHAVIOUR
//  Reset: state IDLE, ptr=0, owner=0, timer=0; grant, resp_valid, resp_err, resp_data, eng_start = 0.
//  States: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: if |req, winner = first set bit searching ptr, ptr+1, ... wrapping mod N_REQ; register
//   owner, timer=0, go BUSY. No req -> stay.
//  BUSY: grant[owner]=1, eng_start=1, operands = req_*[owner] (combinational mux, owner registered).
//   eng_done: resp_data<=eng_result, resp_err<=0, go RESP (done wins over timeout in same cycle).
//   else timer==TIMEOUT-1: resp_data<=0, resp_err<=1, eng_rst pulses 1 cycle, go RESP. else timer++.
//  RESP: resp_valid[owner]=1 for exactly this cycle, grant held; ptr<=(owner+1) mod N_REQ; go IDLE.
//  Latency: req seen in IDLE at cycle 0 -> BUSY/eng_start at 1; eng_done at cycle k -> resp_valid at k+1.
//   Min 3 cycles between grants (IDLE, BUSY, RESP); engine time adds to BUSY.
//  Requester protocol: hold req and operands stable until its resp_valid; may keep req high to
//   re-request (treated as new request in next IDLE, after other pending requesters per ptr).
//  req[owner] dropped during BUSY: protocol violation; arbiter completes the transaction and still
//   pulses resp_valid (result discarded by requester). Other req changes while BUSY are ignored.
//  eng_done outside BUSY is ignored. Simultaneous reqs: ptr order only; no starvation
//   (each requester waits at most N_REQ-1 transactions).
//  Async reset mid-transaction: everything returns to reset values immediately; no resp_valid.
//  Widths: owner/ptr $clog2(N_REQ) bits, wrap explicitly for non-power-of-2 N_REQ;
//   timer $clog2(TIMEOUT+1) bits. resp_data passes eng_result unmodified (no saturation).
// STRUCTURE
//  conv_pkg: WIN_BITS=200, typedef logic signed [7:0] pix_t; typedef arb_state_t {IDLE,BUSY,RESP}.
//  Sub-module rr_pick #(N) (req, ptr -> one-hot + index, found): pure combinational round-robin
//   picker, reusable by future weight-buffer arbiters. Operand mux, FSM, timer in top module.
// TESTING
//  Single req[2]=1, engine model done after 5 cycles, result 1234 -> eng_start high 5 cycles,
//   resp_valid=4'b0100, resp_data=1234, resp_err=0, grant 0 in next IDLE.
//  req=4'b1111 held continuously, ptr=0 -> grants in order 0,1,2,3,0; each resp routed to its owner.
//  Engine never asserts done, TIMEOUT=8 -> after 8 BUSY cycles eng_rst 1-cycle pulse,
//   resp_valid to owner, resp_err=1, resp_data=0; next req served normally.
//  eng_done and timer==TIMEOUT-1 same cycle -> resp_err=0, resp_data=eng_result, no eng_rst pulse.
//  rst_n low mid-BUSY (asynchronous, between edges) -> grant/eng_start drop at once, no resp_valid;
//   after release req[1] alone is granted first (ptr=0 search finds 1).
//  Engine result -2^31 with operands all -128 checks operand mux: eng_window equals req_window[owner]
//   bit-exact every BUSY cycle; N_REQ=3 run checks ptr wrap 2->0.

Source files
------------

// File: rtl/conv_engine_arbiter_pkg.sv
// conv_pkg: shared types for the conv engine arbiter slice.
// Window width, pixel type, arbiter state encoding, index wrap helper.
package conv_pkg;

  localparam int WIN_BITS = 200;

  typedef logic signed [7:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  function automatic int next_idx(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/conv_engine_arbiter_if.sv
// conv_engine_arbiter_if: requester bus plus engine link of the arbiter.
// slave = arbiter side, master = requesters/engine side.
interface conv_engine_arbiter_if #(
  parameter int N_REQ = 4
);
  import conv_pkg::*;

  logic [N_REQ-1:0]          req;
  logic [N_REQ*WIN_BITS-1:0] req_window;
  logic [N_REQ*WIN_BITS-1:0] req_weights;
  logic [N_REQ-1:0]          grant;
  logic [N_REQ-1:0]          resp_valid;
  logic                      resp_err;
  logic signed [31:0]        resp_data;
  logic                      eng_start;
  logic [WIN_BITS-1:0]       eng_window;
  logic [WIN_BITS-1:0]       eng_weights;
  logic                      eng_rst;
  logic                      eng_done;
  logic signed [31:0]        eng_result;

  modport slave (
    input  req, req_window, req_weights,
    input  eng_done, eng_result,
    output grant, resp_valid, resp_err, resp_data,
    output eng_start, eng_window, eng_weights, eng_rst
  );

  modport master (
    output req, req_window, req_weights,
    output eng_done, eng_result,
    input  grant, resp_valid, resp_err, resp_data,
    input  eng_start, eng_window, eng_weights, eng_rst
  );

endinterface

// File: rtl/conv_engine_arbiter_pick.sv
// rr_pick: combinational round-robin picker, first set req from ptr upward.
// Ports: req, ptr in; onehot, idx, found out.
module rr_pick #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin : pick
    int j;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = W'(j);
      end
    end
  end

endmodule

// File: rtl/conv_engine_arbiter.sv
// conv_engine_arbiter: round-robin sharing of one 5x5 conv engine, with timeout abort.
// Ports: clk, rst_n (async active-low), bus (slave: req/resp side and engine link).
module conv_engine_arbiter
  import conv_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_engine_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [PW-1:0]      owner_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      pick_idx;
  logic [N_REQ-1:0]   owner_oh_q;
  logic [N_REQ-1:0]   pick_oh;
  logic               pick_found;
  logic [TW-1:0]      timer_q;
  logic signed [31:0] resp_data_q;
  logic               resp_err_q;
  logic               abort_q;
  logic               tmo;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign tmo = (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pick_found) state_d = BUSY;
      BUSY: if (bus.eng_done || tmo) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= '0;
      owner_oh_q  <= '0;
      ptr_q       <= '0;
      timer_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q    <= pick_idx;
            owner_oh_q <= pick_oh;
            timer_q    <= '0;
          end
        end
        BUSY: begin
          // done outranks a timeout landing on the same edge
          if (bus.eng_done) begin
            resp_data_q <= bus.eng_result;
            resp_err_q  <= 1'b0;
          end else if (tmo) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
            abort_q     <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: ptr_q <= PW'(next_idx(int'(owner_q), N_REQ));
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.grant       = '0;
    bus.resp_valid  = '0;
    bus.eng_start   = 1'b0;
    bus.eng_window  = '0;
    bus.eng_weights = '0;
    unique case (state_q)
      BUSY: begin
        bus.grant     = owner_oh_q;
        bus.eng_start = 1'b1;
        for (int r = 0; r < N_REQ; r++) begin
          if (owner_q == PW'(r)) begin
            bus.eng_window  = bus.req_window[r*WIN_BITS +: WIN_BITS];
            bus.eng_weights = bus.req_weights[r*WIN_BITS +: WIN_BITS];
          end
        end
      end
      RESP: begin
        bus.grant      = owner_oh_q;
        bus.resp_valid = owner_oh_q;
      end
      default: ;
    endcase
  end

  assign bus.resp_data = resp_data_q;
  assign bus.resp_err  = resp_err_q;
  assign bus.eng_rst   = ~rst_n | abort_q;

endmodule

// File: tb/tb_conv_engine_arbiter.sv
// tb_conv_engine_arbiter: scoreboard bench with engine model and random requesters.
// Covers N_REQ=4/TIMEOUT=8 plus an N_REQ=3 wrap instance.
module tb_conv_engine_arbiter;
  import conv_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 8;
  localparam int N3  = 3;

  typedef struct {
    int                 owner;
    bit                 err;
    logic signed [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_engine_arbiter_if #(.N_REQ(N))  bus ();
  conv_engine_arbiter_if #(.N_REQ(N3)) bus3 ();

  conv_engine_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  conv_engine_arbiter #(.N_REQ(N3), .TIMEOUT(TMO)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  int checks = 0;
  int errors = 0;

  logic [WIN_BITS-1:0] win [N];
  logic [WIN_BITS-1:0] wts [N];
  int                  force_lat = 0;
  bit                  force_res_en = 1'b0;
  logic signed [31:0]  force_res = '0;

  exp_t exp_q [$];
  int   act_order [$];
  int   resp_cnt [N];
  int   tot_resp = 0;
  int   exp_pulses = 0;
  int   pulses = 0;
  int   last_len = 0;

  always_comb begin
    bus.req_window  = '0;
    bus.req_weights = '0;
    for (int r = 0; r < N; r++) begin
      bus.req_window[r*WIN_BITS +: WIN_BITS]  = win[r];
      bus.req_weights[r*WIN_BITS +: WIN_BITS] = wts[r];
    end
  end

  assign bus3.req_window  = '0;
  assign bus3.req_weights = '0;

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic signed [31:0] dot(input logic [WIN_BITS-1:0] a,
                                              input logic [WIN_BITS-1:0] b);
    int   s;
    pix_t x;
    pix_t y;
    s = 0;
    for (int i = 0; i < 25; i++) begin
      x = a[8*i +: 8];
      y = b[8*i +: 8];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  // reference arbitration rule: first requester at or after ptr, wrapping
  function automatic int rr_ref(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < N; i++)
      if (g[i]) return i;
    return -1;
  endfunction

  function automatic logic [WIN_BITS-1:0] rnd_op();
    logic [WIN_BITS-1:0] v;
    for (int i = 0; i < 25; i++) v[8*i +: 8] = 8'($urandom);
    if ($urandom_range(0, 7) == 0) v = {25{8'h80}};
    return v;
  endfunction

  // engine model plus expectation generator
  int            cnt = 0;
  int            lat = 0;
  int            cur_w = 0;
  int            m_ptr = 0;
  logic [N-1:0]  req_prev = '0;

  always @(negedge clk) begin : model
    exp_t e;
    if (!rst_n) begin
      cnt = 0;
      m_ptr = 0;
      req_prev = '0;
      bus.eng_done = 1'b0;
      bus.eng_result = '0;
    end else begin
      if (bus.eng_start) begin
        cnt++;
        if (cnt == 1) begin
          cur_w = rr_ref(req_prev, m_ptr);
          if (cur_w < 0) begin
            chk("grant_without_req", bus.grant, '0);
            cur_w = (oh2i(bus.grant) < 0) ? 0 : oh2i(bus.grant);
          end
          chk("grant_winner", bus.grant, oh(cur_w));
          act_order.push_back(oh2i(bus.grant));
          lat = (force_lat != 0) ? force_lat : $urandom_range(1, 12);
          e.owner = cur_w;
          e.err   = (lat > TMO);
          e.data  = e.err ? 32'sd0
                  : (force_res_en ? force_res : dot(win[cur_w], wts[cur_w]));
          exp_q.push_back(e);
          m_ptr = (cur_w + 1) % N;
        end
        chk("eng_window", bus.eng_window, win[cur_w]);
        chk("eng_weights", bus.eng_weights, wts[cur_w]);
        chk("grant_busy", bus.grant, oh(cur_w));
        bus.eng_done = (cnt == lat);
        bus.eng_result = force_res_en ? force_res
                       : dot(bus.eng_window, bus.eng_weights);
        last_len = cnt;
      end else begin
        cnt = 0;
        chk("eng_window_idle", bus.eng_window, '0);
        // stray done outside BUSY must be ignored
        bus.eng_done = ($urandom_range(0, 3) == 0);
        bus.eng_result = $urandom;
      end
      if (bus.eng_rst) pulses++;
      req_prev = bus.req;
    end
  end

  // monitor: pops the scoreboard whenever a response appears
  bit was_resp = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      was_resp = 1'b0;
    end else if (bus.resp_valid != '0) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", bus.resp_valid, '0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_valid", bus.resp_valid, oh(e.owner));
        chk("resp_err", bus.resp_err, e.err);
        chk("resp_data", bus.resp_data, e.data);
        chk("grant_resp", bus.grant, oh(e.owner));
        if (e.err) exp_pulses++;
        resp_cnt[e.owner]++;
        tot_resp++;
      end
      was_resp = 1'b1;
    end else begin
      if (was_resp) chk("grant_after_resp", bus.grant, '0);
      was_resp = 1'b0;
    end
  end

  // N_REQ=3 instance: engine answers on the first BUSY cycle
  logic [N3-1:0] g3_prev = '0;
  int            order3 [$];
  int            r3 = 0;

  always @(negedge clk) begin : model3
    if (!rst_n) begin
      g3_prev = '0;
      bus3.eng_done = 1'b0;
      bus3.eng_result = '0;
    end else begin
      bus3.eng_done = bus3.eng_start;
      bus3.eng_result = 32'sd77;
      if (bus3.grant != '0 && g3_prev == '0) order3.push_back(oh2i({1'b0, bus3.grant}));
      if (bus3.resp_valid != '0) begin
        r3++;
        chk("n3_resp_data", bus3.resp_data, 32'sd77);
        chk("n3_resp_owner", bus3.resp_valid, bus3.grant);
      end
      g3_prev = bus3.grant;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_total(input int n, input string nm);
    int b;
    b = 0;
    while (tot_resp < n && b < 300) begin
      cyc();
      b++;
    end
    chk(nm, 256'(tot_resp >= n), 256'(1));
  endtask

  task automatic run_one(input logic [N-1:0] r, input int l, input string nm);
    int n0;
    n0 = tot_resp;
    force_lat = l;
    bus.req = r;
    wait_total(n0 + 1, nm);
    bus.req = '0;
  endtask

  task automatic rand_run(input int n);
    int seen [N];
    for (int r = 0; r < N; r++) seen[r] = resp_cnt[r];
    repeat (n) begin
      cyc();
      for (int r = 0; r < N; r++) begin
        if (resp_cnt[r] != seen[r]) begin
          seen[r] = resp_cnt[r];
          if ($urandom_range(0, 1) == 1) begin
            bus.req[r] = 1'b0;
          end else begin
            win[r] = rnd_op();
            wts[r] = rnd_op();
          end
        end else if (!bus.req[r] && $urandom_range(0, 3) == 0) begin
          win[r] = rnd_op();
          wts[r] = rnd_op();
          bus.req[r] = 1'b1;
        end
      end
    end
  endtask

  initial begin : stim
    int exp_ord [5];
    int exp3 [4];
    int p0;
    int b;
    exp_ord = '{0, 1, 2, 3, 0};
    exp3 = '{0, 1, 2, 0};
    bus.req = '0;
    bus3.req = '0;
    for (int r = 0; r < N; r++) begin
      win[r] = rnd_op();
      wts[r] = rnd_op();
    end

    repeat (3) @(posedge clk);
    #2;
    chk("rst_grant", bus.grant, '0);
    chk("rst_resp_valid", bus.resp_valid, '0);
    chk("rst_resp_err", bus.resp_err, 1'b0);
    chk("rst_resp_data", bus.resp_data, '0);
    chk("rst_eng_start", bus.eng_start, 1'b0);
    chk("rst_eng_rst", bus.eng_rst, 1'b1);
    chk("rst_eng_window", bus.eng_window, '0);
    rst_n = 1'b1;
    cyc();
    chk("eng_rst_released", bus.eng_rst, 1'b0);

    // all four requesting from ptr=0
    act_order.delete();
    force_lat = 2;
    bus.req = '1;
    wait_total(5, "order_wait");
    bus.req = '0;
    chk("order_count", act_order.size(), 5);
    for (int i = 0; i < 5 && i < act_order.size(); i++)
      chk("order_grant", act_order[i], exp_ord[i]);

    // single requester 2, 5-cycle engine, fixed result
    force_res_en = 1'b1;
    force_res = 32'sd1234;
    run_one(4'b0100, 5, "single_wait");
    chk("single_busy_len", last_len, 5);
    force_res_en = 1'b0;

    // engine never finishes
    p0 = pulses;
    run_one(4'b0001, 20, "tmo_wait");
    chk("tmo_busy_len", last_len, TMO);
    chk("tmo_abort_pulse", pulses - p0, 1);
    run_one(4'b0010, 3, "after_tmo_wait");
    chk("after_tmo_pulse", pulses - p0, 1);

    // done on the final allowed cycle
    p0 = pulses;
    run_one(4'b1000, TMO, "edge_wait");
    chk("edge_busy_len", last_len, TMO);
    chk("edge_no_pulse", pulses - p0, 0);

    // extreme operands, most negative result
    win[0] = {25{8'h80}};
    wts[0] = {25{8'h80}};
    force_res_en = 1'b1;
    force_res = 32'sh8000_0000;
    run_one(4'b0001, 4, "min_wait");
    force_res_en = 1'b0;

    // asynchronous reset in the middle of BUSY
    force_lat = 20;
    bus.req = 4'b1000;
    b = 0;
    while (bus.grant == '0 && b < 20) begin
      cyc();
      b++;
    end
    chk("midrst_granted", bus.grant, 4'b1000);
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", bus.grant, '0);
    chk("midrst_eng_start", bus.eng_start, 1'b0);
    chk("midrst_resp_valid", bus.resp_valid, '0);
    chk("midrst_eng_rst", bus.eng_rst, 1'b1);
    bus.req = 4'b0010;
    force_lat = 2;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    act_order.delete();
    wait_total(tot_resp + 1, "post_rst_wait");
    bus.req = '0;
    chk("post_rst_count", act_order.size(), 1);
    if (act_order.size() > 0) chk("post_rst_first", act_order[0], 1);

    // random traffic
    force_lat = 0;
    rand_run(1500);
    bus.req = '0;
    repeat (30) cyc();
    chk("queue_drain", exp_q.size(), 0);
    chk("abort_count", pulses, exp_pulses);

    // pointer wrap with three requesters
    order3.delete();
    p0 = r3;
    bus3.req = '1;
    b = 0;
    while (r3 < p0 + 4 && b < 100) begin
      cyc();
      b++;
    end
    bus3.req = '0;
    chk("n3_count", order3.size(), 4);
    for (int i = 0; i < 4 && i < order3.size(); i++)
      chk("n3_order", order3[i], exp3[i]);

    repeat (5) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
